decoder_scan_driver: RTL and testbench



---
 rtl/decoder_scan_pkg.sv | 20 ++
 rtl/decoder_scan_driver_dwell_timer.sv | 36 +++
 rtl/decoder_scan_driver.sv | 138 +++++++++++++
 tb/tb_decoder_scan_driver.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/decoder_scan_pkg.sv
// Shared types and helpers for the 2-to-4 decoder select sequencer.
package decoder_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } scan_state_t;

  localparam int IDX_W = 2;
  localparam logic [IDX_W-1:0] IDX_FIRST_UP = 2'd0;
  localparam logic [IDX_W-1:0] IDX_FIRST_DN = 2'd3;

  // Two-bit arithmetic gives the 3->0 / 0->3 wrap for free.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                 input logic             dir);
    return dir ? (idx - 2'd1) : (idx + 2'd1);
  endfunction

endpackage

// File: rtl/decoder_scan_driver_dwell_timer.sv
// Dwell counter: counts while run is high, flags and self-clears on the last cycle of a dwell.
module dwell_timer #(
  parameter int DWELL_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = expire ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_scan_driver.sv
// Select-pair sequencer for the 2-to-4 NAND decoder: one-shot/continuous, up/down, pause/resume.
// Optional `DECODER_SCAN_STEP_EN adds a step input that single-steps the index while paused.
module decoder_scan_driver
  import decoder_scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic start,
  input  logic stop,
  input  logic mode,
  input  logic dir,
`ifdef DECODER_SCAN_STEP_EN
  input  logic step,
`endif
  output logic a,
  output logic b,
  output logic sel_valid,
  output logic busy,
  output logic done
);

  if (DWELL_CYCLES < 1 || DWELL_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_dwell
    $error("decoder_scan_driver: DWELL_CYCLES out of range 1..2^CNT_W-1");
  end

  scan_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dir_q, dir_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             sel_valid_q, busy_q;
  logic             tmr_clr, tmr_expire, step_w;
  logic [IDX_W-1:0] last_idx;

`ifdef DECODER_SCAN_STEP_EN
  assign step_w = step;
`else
  assign step_w = 1'b0;
`endif

  assign last_idx = dir_q ? IDX_FIRST_UP : IDX_FIRST_DN;

  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES),
    .CNT_W       (CNT_W)
  ) u_dwell_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .run   (state_q == RUN),
    .expire(tmr_expire)
  );

  // The dwell keeps counting on the cycle en drops, so a paused index still
  // gets exactly DWELL_CYCLES valid cycles in total.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    tmr_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && en && !stop) begin
          state_d = RUN;
          idx_d   = dir ? IDX_FIRST_DN : IDX_FIRST_UP;
          dir_d   = dir;
          mode_d  = mode;
          tmr_clr = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          tmr_clr = 1'b1;
        end else if (tmr_expire && mode_q && idx_q == last_idx) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          if (tmr_expire) idx_d = next_idx(idx_q, dir_q);
          if (!en) state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d = IDLE;
          tmr_clr = 1'b1;
        end else if (step_w) begin
          tmr_clr = 1'b1;
          if (mode_q && idx_q == last_idx) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = next_idx(idx_q, dir_q);
          end
        end else if (en) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      dir_q       <= 1'b0;
      mode_q      <= 1'b0;
      done_q      <= 1'b0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dir_q       <= dir_d;
      mode_q      <= mode_d;
      done_q      <= done_d;
      sel_valid_q <= (state_d == RUN);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign a         = idx_q[1];
  assign b         = idx_q[0];
  assign sel_valid = sel_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_decoder_scan_driver.sv
// Directed, table-driven bench for decoder_scan_driver (DWELL_CYCLES=4) plus a DWELL_CYCLES=1 instance.
module tb_decoder_scan_driver;

  typedef struct {
    logic       rst_n, en, start, stop, mode, dir, step;
    logic [1:0] ab;
    logic       sv, bz, dn;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, en, start, stop, mode, dir, step;
  logic a, b, sel_valid, busy, done;

  logic rst1_n, start1, mode1;
  logic a1, b1, sv1, busy1, done1;
  logic step1;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  decoder_scan_driver #(.DWELL_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop),
    .mode(mode), .dir(dir),
`ifdef DECODER_SCAN_STEP_EN
    .step(step),
`endif
    .a(a), .b(b), .sel_valid(sel_valid), .busy(busy), .done(done)
  );

  decoder_scan_driver #(.DWELL_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst1_n), .en(1'b1), .start(start1), .stop(1'b0),
    .mode(mode1), .dir(1'b0),
`ifdef DECODER_SCAN_STEP_EN
    .step(step1),
`endif
    .a(a1), .b(b1), .sel_valid(sv1), .busy(busy1), .done(done1)
  );

  task automatic add(input int n, input logic r, e, s, p, m, d, st,
                     input logic [1:0] ab, input logic sv, bz, dn);
    vec_t v;
    v.rst_n = r; v.en = e; v.start = s; v.stop = p; v.mode = m; v.dir = d; v.step = st;
    v.ab = ab; v.sv = sv; v.bz = bz; v.dn = dn;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check5(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got {a,b,sel_valid,busy,done}=%b expected %b", name, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; dir = 1'b0; step = 1'b0;
    rst1_n = 1'b0; start1 = 1'b0; mode1 = 1'b1; step1 = 1'b0;

    // reset held with start asserted, then idle; ignored starts
    add(3, 0,1,1,0,1,0,0, 2'd0,0,0,0);
    add(2, 1,1,0,0,0,0,0, 2'd0,0,0,0);
    add(1, 1,0,1,0,1,0,0, 2'd0,0,0,0);
    add(1, 1,1,1,1,1,0,0, 2'd0,0,0,0);
    // one-shot up
    add(1, 1,1,1,0,1,0,0, 2'd0,1,1,0);
    add(3, 1,1,0,0,1,0,0, 2'd0,1,1,0);
    add(4, 1,1,0,0,1,0,0, 2'd1,1,1,0);
    add(4, 1,1,0,0,1,0,0, 2'd2,1,1,0);
    add(4, 1,1,0,0,1,0,0, 2'd3,1,1,0);
    add(1, 1,1,0,0,1,0,0, 2'd3,0,0,1);
    add(1, 1,1,0,0,1,0,0, 2'd3,0,0,0);
    // one-shot down; mode/dir inputs flipped after start must not matter
    add(1, 1,1,1,0,1,1,0, 2'd3,1,1,0);
    add(3, 1,1,0,0,0,0,0, 2'd3,1,1,0);
    add(4, 1,1,0,0,0,0,0, 2'd2,1,1,0);
    add(4, 1,1,0,0,0,0,0, 2'd1,1,1,0);
    add(4, 1,1,0,0,0,0,0, 2'd0,1,1,0);
    add(1, 1,1,0,0,0,0,0, 2'd0,0,0,1);
    add(1, 1,1,0,0,0,0,0, 2'd0,0,0,0);
    // continuous up with wrap, pause mid-dwell, start while busy, stop at 10
    add(1, 1,1,1,0,0,0,0, 2'd0,1,1,0);
    add(3, 1,1,0,0,0,0,0, 2'd0,1,1,0);
    add(4, 1,1,0,0,0,0,0, 2'd1,1,1,0);
    add(4, 1,1,0,0,0,0,0, 2'd2,1,1,0);
    add(4, 1,1,0,0,0,0,0, 2'd3,1,1,0);
    add(4, 1,1,0,0,0,0,0, 2'd0,1,1,0);
    add(2, 1,1,0,0,0,0,0, 2'd1,1,1,0);
    add(5, 1,0,0,0,0,0,0, 2'd1,0,1,0);
    add(2, 1,1,0,0,0,0,0, 2'd1,1,1,0);
    add(1, 1,1,1,0,1,1,0, 2'd2,1,1,0);
    add(3, 1,1,0,0,0,0,0, 2'd2,1,1,0);
    add(4, 1,1,0,0,0,0,0, 2'd3,1,1,0);
    add(4, 1,1,0,0,0,0,0, 2'd0,1,1,0);
    add(4, 1,1,0,0,0,0,0, 2'd1,1,1,0);
    add(2, 1,1,0,0,0,0,0, 2'd2,1,1,0);
    add(1, 1,1,0,1,0,0,0, 2'd2,0,0,0);
    add(2, 1,1,0,0,0,0,0, 2'd2,0,0,0);
    // reset mid one-shot scan: no done
    add(1, 1,1,1,0,1,0,0, 2'd0,1,1,0);
    add(1, 1,1,0,0,1,0,0, 2'd0,1,1,0);
    add(1, 0,1,0,0,1,0,0, 2'd0,0,0,0);
    add(2, 1,1,0,0,1,0,0, 2'd0,0,0,0);
`ifdef DECODER_SCAN_STEP_EN
    // pause at 01, step twice, resume with a fresh dwell
    add(1, 1,1,1,0,1,0,0, 2'd0,1,1,0);
    add(3, 1,1,0,0,1,0,0, 2'd0,1,1,0);
    add(1, 1,1,0,0,1,0,0, 2'd1,1,1,0);
    add(1, 1,0,0,0,1,0,0, 2'd1,0,1,0);
    add(1, 1,0,0,0,1,0,1, 2'd2,0,1,0);
    add(1, 1,0,0,0,1,0,1, 2'd3,0,1,0);
    add(1, 1,0,0,0,1,0,0, 2'd3,0,1,0);
    add(4, 1,1,0,0,1,0,0, 2'd3,1,1,0);
    add(1, 1,1,0,0,1,0,0, 2'd3,0,0,1);
    add(1, 1,1,0,0,1,0,0, 2'd3,0,0,0);
    // one-shot up, step past 11 ends the pass
    add(1, 1,1,1,0,1,0,0, 2'd0,1,1,0);
    add(1, 1,0,0,0,1,0,0, 2'd0,0,1,0);
    add(1, 1,0,0,0,1,0,1, 2'd1,0,1,0);
    add(1, 1,0,0,0,1,0,1, 2'd2,0,1,0);
    add(1, 1,0,0,0,1,0,1, 2'd3,0,1,0);
    add(1, 1,0,0,0,1,0,1, 2'd3,0,0,1);
    add(1, 1,0,0,0,1,0,0, 2'd3,0,0,0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; en = vecs[i].en; start = vecs[i].start; stop = vecs[i].stop;
      mode = vecs[i].mode; dir = vecs[i].dir; step = vecs[i].step;
      @(posedge clk);
      #1;
      check5($sformatf("vec%0d", i), {a, b, sel_valid, busy, done},
             {vecs[i].ab, vecs[i].sv, vecs[i].bz, vecs[i].dn});
    end

    // DWELL_CYCLES=1: index changes every cycle, a one-shot pass is 4 cycles
    rst1_n = 1'b0;
    @(posedge clk); #1;
    check5("d1_reset", {a1, b1, sv1, busy1, done1}, 5'b00000);
    rst1_n = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    check5("d1_idx0", {a1, b1, sv1, busy1, done1}, 5'b00110);
    start1 = 1'b0;
    @(posedge clk); #1;
    check5("d1_idx1", {a1, b1, sv1, busy1, done1}, 5'b01110);
    @(posedge clk); #1;
    check5("d1_idx2", {a1, b1, sv1, busy1, done1}, 5'b10110);
    @(posedge clk); #1;
    check5("d1_idx3", {a1, b1, sv1, busy1, done1}, 5'b11110);
    @(posedge clk); #1;
    check5("d1_done", {a1, b1, sv1, busy1, done1}, 5'b11001);
    @(posedge clk); #1;
    check5("d1_idle", {a1, b1, sv1, busy1, done1}, 5'b11000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
